// File: rtl/concat_sched_pkg.sv
// Shared types, widths and helpers for the concat_sched bit-packing scheduler.
package concat_sched_pkg;

   localparam int unsigned N_SRC = 3;
   localparam int unsigned IN_W  = 6;
   localparam int unsigned OUT_W = 11;
   localparam int unsigned LEN_W = 3;
   localparam int unsigned ACC_W = OUT_W + IN_W - 1;
   localparam int unsigned CNT_W = 5;
   localparam int unsigned IDX_W = 2;

   localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_W);
   localparam logic [LEN_W-1:0] IN_W_L  = LEN_W'(IN_W);

   typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

   // Bitwise 2-of-3 majority; callers zero-extend narrower fields.
   function automatic logic [7:0] maj3(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/concat_rr_arb.sv
// Round-robin arbiter: first valid source after ptr_i (with wrap) wins.
module concat_rr_arb
   import concat_sched_pkg::*;
#(
   parameter int unsigned NumSrc = N_SRC
) (
   input  logic [NumSrc-1:0] valid_i,
   input  logic              en_i,
   input  logic [IDX_W-1:0]  ptr_i,
   output logic [NumSrc-1:0] gnt_o,
   output logic [IDX_W-1:0]  idx_o
);

   logic             found;
   logic [IDX_W-1:0] k;

   // Search ptr+1, ptr+2, ... wrapping; the previous winner is visited last.
   always_comb begin
      gnt_o = '0;
      idx_o = ptr_i;
      found = 1'b0;
      k     = '0;
      for (int unsigned i = 1; i <= NumSrc; i++) begin
         k = IDX_W'((32'(ptr_i) + i) % NumSrc);
         if (en_i && !found && valid_i[k]) begin
            found    = 1'b1;
            gnt_o[k] = 1'b1;
            idx_o    = k;
         end
      end
   end

endmodule

// File: rtl/concat_sched.sv
// Round-robin scheduler packing variable-length fragments MSB-first into
// fixed OUT_W-bit words. Define CONCAT_SCHED_TMR_EN to triplicate state,
// cnt and rr_ptr with majority voting and a sticky tmr_err flag.
module concat_sched
   import concat_sched_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_SRC-1:0]       in_valid,
   output logic [N_SRC-1:0]       in_ready,
   input  logic [N_SRC*IN_W-1:0]  in_data,
   input  logic [N_SRC*LEN_W-1:0] in_len,
   input  logic                   flush,
   output logic                   flush_busy,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_W-1:0]       out_data,
   output logic                   out_last,
   output logic [4:0]             fill_level,
   output logic                   tmr_err
);

`ifdef CONCAT_SCHED_TMR_EN
   localparam int unsigned NCopy = 3;
`else
   localparam int unsigned NCopy = 1;
`endif

   state_e           state_q [NCopy];
   logic [CNT_W-1:0] cnt_q   [NCopy];
   logic [IDX_W-1:0] rr_q    [NCopy];
   state_e           state_d, state_v;
   logic [CNT_W-1:0] cnt_d, cnt_v;
   logic [IDX_W-1:0] rr_d, rr_v;

   logic [ACC_W-1:0] acc_q, acc_d, next_acc, mask;
   logic [CNT_W-1:0] next_cnt, len_eff;
   logic [OUT_W-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [N_SRC-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic [IN_W-1:0]  frag_data;
   logic [LEN_W-1:0] len_raw;
   logic             grant_en, accept, slot_free;

`ifdef CONCAT_SCHED_TMR_EN
   logic [7:0] st_m, cnt_m, rr_m;
   logic       tmr_err_q, tmr_err_d, unused_vote;

   // Majority vote of the three copies; any disagreement latches tmr_err.
   always_comb begin
      st_m      = maj3(8'(state_q[0]), 8'(state_q[1]), 8'(state_q[2]));
      cnt_m     = maj3(8'(cnt_q[0]), 8'(cnt_q[1]), 8'(cnt_q[2]));
      rr_m      = maj3(8'(rr_q[0]), 8'(rr_q[1]), 8'(rr_q[2]));
      state_v   = state_e'(st_m[1:0]);
      cnt_v     = cnt_m[CNT_W-1:0];
      rr_v      = rr_m[IDX_W-1:0];
      tmr_err_d = tmr_err_q
                | (state_q[0] != state_q[1]) | (state_q[1] != state_q[2])
                | (cnt_q[0] != cnt_q[1]) | (cnt_q[1] != cnt_q[2])
                | (rr_q[0] != rr_q[1]) | (rr_q[1] != rr_q[2]);
   end

   assign unused_vote = ^{st_m[7:2], cnt_m[7:CNT_W], rr_m[7:IDX_W]};

   // Sticky voter error, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmr_err_q <= 1'b0;
      else        tmr_err_q <= tmr_err_d;
   end

   assign tmr_err = tmr_err_q;
`else
   assign state_v = state_q[0];
   assign cnt_v   = cnt_q[0];
   assign rr_v    = rr_q[0];
   assign tmr_err = 1'b0;
`endif

   assign grant_en  = (state_v == StRun) && (cnt_v < OUT_W_C) && !flush;
   assign slot_free = !out_valid_q || out_ready;

   concat_rr_arb #(
      .NumSrc (N_SRC)
   ) u_arb (
      .valid_i (in_valid),
      .en_i    (grant_en),
      .ptr_i   (rr_v),
      .gnt_o   (gnt),
      .idx_o   (gnt_idx)
   );

   assign accept = |gnt;

   // Select the granted fragment and append it below the held bits.
   always_comb begin
      frag_data = '0;
      len_raw   = '0;
      for (int k = 0; k < N_SRC; k++) begin
         if (gnt[k]) begin
            frag_data = in_data[k*IN_W +: IN_W];
            len_raw   = in_len[k*LEN_W +: LEN_W];
         end
      end
      len_eff  = (len_raw > IN_W_L) ? CNT_W'(IN_W) : CNT_W'(len_raw);
      mask     = (ACC_W'(1) << len_eff) - ACC_W'(1);
      next_acc = accept ? ((acc_q << len_eff) | (ACC_W'(frag_data) & mask)) : acc_q;
      next_cnt = accept ? (cnt_v + len_eff) : cnt_v;
   end

   // Next-state: word extraction, flush padding and FSM transitions.
   always_comb begin
      state_d     = state_v;
      cnt_d       = next_cnt;
      acc_d       = next_acc;
      rr_d        = accept ? gnt_idx : rr_v;
      out_valid_d = out_valid_q && !out_ready;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;

      // A full word leaves whenever the output slot is free, in any state.
      if (next_cnt >= OUT_W_C && slot_free) begin
         out_data_d  = OUT_W'(next_acc >> (next_cnt - OUT_W_C));
         out_valid_d = 1'b1;
         out_last_d  = 1'b0;
         cnt_d       = next_cnt - OUT_W_C;
      end

      unique case (state_v)
         StRun: begin
            if (flush)                                 state_d = StFlush;
            else if (cnt_v >= OUT_W_C && !slot_free)   state_d = StStall;
         end
         StStall: begin
            if (slot_free) state_d = StRun;
         end
         StFlush: begin
            if (cnt_v == '0) begin
               state_d = StRun;
            end else if (cnt_v < OUT_W_C && slot_free) begin
               // Left-justify the residue; bits above cnt fall off the top.
               out_data_d  = OUT_W'(acc_q << (OUT_W_C - cnt_v));
               out_valid_d = 1'b1;
               out_last_d  = 1'b1;
               cnt_d       = '0;
               acc_d       = '0;
            end
         end
         default: state_d = StRun;
      endcase
   end

   // State, accumulator and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCopy; i++) begin
            state_q[i] <= StRun;
            cnt_q[i]   <= '0;
            rr_q[i]    <= IDX_W'(N_SRC - 1);
         end
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         for (int i = 0; i < NCopy; i++) begin
            state_q[i] <= state_d;
            cnt_q[i]   <= cnt_d;
            rr_q[i]    <= rr_d;
         end
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign in_ready   = gnt;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign flush_busy = (state_v == StFlush);
   assign fill_level = cnt_v;

endmodule

// File: tb/tb_concat_sched.sv
// Directed bench for concat_sched with hand-computed expected words.
module tb_concat_sched;

   logic        clk;
   logic        rst_n;
   logic [2:0]  in_valid;
   logic [2:0]  in_ready;
   logic [17:0] in_data;
   logic [8:0]  in_len;
   logic        flush;
   logic        flush_busy;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] out_data;
   logic        out_last;
   logic [4:0]  fill_level;
   logic        tmr_err;

   int n_checks = 0;
   int n_errors = 0;

   concat_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_len     (in_len),
      .flush      (flush),
      .flush_busy (flush_busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .fill_level (fill_level),
      .tmr_err    (tmr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int k, input logic [2:0] len, input logic [5:0] data);
      in_valid[k]       = 1'b1;
      in_data[k*6 +: 6] = data;
      in_len[k*3 +: 3]  = len;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      in_len    = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   logic [10:0] words [4];
   int          nw;
   logic [2:0]  exp_gnt;

   initial begin
      apply_reset();
      check_eq("rst_in_ready", 32'(in_ready), 0);
      check_eq("rst_out_valid", 32'(out_valid), 0);
      check_eq("rst_out_data", 32'(out_data), 0);
      check_eq("rst_out_last", 32'(out_last), 0);
      check_eq("rst_flush_busy", 32'(flush_busy), 0);
      check_eq("rst_fill", 32'(fill_level), 0);
      check_eq("rst_tmr_err", 32'(tmr_err), 0);

      // Two fragments 6+5 bits make exactly one word.
      out_ready = 1'b1;
      set_src(0, 3'd6, 6'b101010);
      #1 check_eq("t1_gnt0", 32'(in_ready), 'b001);
      step();
      in_valid = '0;
      check_eq("t1_fill6", 32'(fill_level), 6);
      check_eq("t1_no_word_yet", 32'(out_valid), 0);
      set_src(1, 3'd5, 6'b011001);
      #1 check_eq("t1_gnt1", 32'(in_ready), 'b010);
      step();
      in_valid = '0;
      check_eq("t1_valid", 32'(out_valid), 1);
      check_eq("t1_data", 32'(out_data), 'h559);
      check_eq("t1_last", 32'(out_last), 0);
      check_eq("t1_fill0", 32'(fill_level), 0);
      step();
      check_eq("t1_valid_drop", 32'(out_valid), 0);

      // Three sources always valid, 4 bits each: grants rotate 0,1,2,...
      apply_reset();
      out_ready = 1'b1;
      set_src(0, 3'd4, 6'h09);
      set_src(1, 3'd4, 6'h06);
      set_src(2, 3'd4, 6'h0F);
      nw = 0;
      for (int i = 0; i < 11; i++) begin
         exp_gnt = 3'b001 << (i % 3);
         #1 check_eq($sformatf("t2_gnt%0d", i), 32'(in_ready), 32'(exp_gnt));
         step();
         if (out_valid) begin
            if (nw < 4) words[nw] = out_data;
            nw++;
         end
      end
      in_valid = '0;
      check_eq("t2_nwords", 32'(nw), 4);
      check_eq("t2_w0", 32'(words[0]), 'h4B7);
      check_eq("t2_w1", 32'(words[1]), 'h65B);
      check_eq("t2_w2", 32'(words[2]), 'h72D);
      check_eq("t2_w3", 32'(words[3]), 'h796);
      check_eq("t2_fill0", 32'(fill_level), 0);

      // Back-pressure: second word waits in STALL until the sink is ready.
      apply_reset();
      set_src(0, 3'd6, 6'b111000);
      step();
      in_valid = '0;
      set_src(1, 3'd5, 6'b011111);
      step();
      in_valid = '0;
      check_eq("t3_w0_valid", 32'(out_valid), 1);
      check_eq("t3_w0_data", 32'(out_data), 'h71F);
      set_src(2, 3'd6, 6'b000111);
      step();
      in_valid = '0;
      set_src(0, 3'd6, 6'b110011);
      step();
      in_valid = '0;
      check_eq("t3_fill12", 32'(fill_level), 12);
      set_src(1, 3'd5, 6'b000000);
      #1 check_eq("t3_no_gnt_full", 32'(in_ready), 0);
      step();
      check_eq("t3_stall_no_gnt", 32'(in_ready), 0);
      check_eq("t3_hold_valid", 32'(out_valid), 1);
      check_eq("t3_hold_data", 32'(out_data), 'h71F);
      in_valid  = '0;
      out_ready = 1'b1;
      step();
      check_eq("t3_w1_valid", 32'(out_valid), 1);
      check_eq("t3_w1_data", 32'(out_data), 'h0F9);
      check_eq("t3_fill1", 32'(fill_level), 1);
      step();
      check_eq("t3_drain", 32'(out_valid), 0);

      // Flush of a 3-bit residue; flush beats a simultaneous request.
      apply_reset();
      out_ready = 1'b1;
      set_src(1, 3'd3, 6'b000111);
      step();
      in_valid = '0;
      check_eq("t4_fill3", 32'(fill_level), 3);
      set_src(0, 3'd4, 6'h0F);
      flush = 1'b1;
      #1 check_eq("t4_flush_wins", 32'(in_ready), 0);
      step();
      check_eq("t4_busy", 32'(flush_busy), 1);
      check_eq("t4_not_yet", 32'(out_valid), 0);
      step();
      check_eq("t4_valid", 32'(out_valid), 1);
      check_eq("t4_data", 32'(out_data), 'h700);
      check_eq("t4_last", 32'(out_last), 1);
      check_eq("t4_fill0", 32'(fill_level), 0);
      flush    = 1'b0;
      in_valid = '0;
      step();
      check_eq("t4_busy_done", 32'(flush_busy), 0);
      check_eq("t4_valid_drop", 32'(out_valid), 0);

      // Flush with an empty accumulator: one-cycle busy pulse, no word.
      apply_reset();
      flush = 1'b1;
      step();
      check_eq("t4e_busy", 32'(flush_busy), 1);
      flush = 1'b0;
      step();
      check_eq("t4e_busy_done", 32'(flush_busy), 0);
      check_eq("t4e_no_word", 32'(out_valid), 0);

      // Length clamp (7 -> 6) and zero-length fragment.
      apply_reset();
      out_ready = 1'b1;
      set_src(2, 3'd7, 6'h3F);
      #1 check_eq("t5_gnt2", 32'(in_ready), 'b100);
      step();
      in_valid = '0;
      check_eq("t5_fill6", 32'(fill_level), 6);
      set_src(0, 3'd0, 6'h3F);
      #1 check_eq("t5_gnt0_len0", 32'(in_ready), 'b001);
      step();
      in_valid = '0;
      check_eq("t5_fill_same", 32'(fill_level), 6);
      set_src(1, 3'd5, 6'h00);
      step();
      in_valid = '0;
      check_eq("t5_valid", 32'(out_valid), 1);
      check_eq("t5_data", 32'(out_data), 'h7E0);

      // Asynchronous reset with a word pending and 9 bits held.
      apply_reset();
      set_src(0, 3'd6, 6'h2A);
      step();
      in_valid = '0;
      set_src(1, 3'd5, 6'h15);
      step();
      in_valid = '0;
      set_src(2, 3'd6, 6'h3F);
      step();
      in_valid = '0;
      set_src(0, 3'd3, 6'h05);
      step();
      in_valid = '0;
      check_eq("t6_pre_valid", 32'(out_valid), 1);
      check_eq("t6_pre_fill", 32'(fill_level), 9);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t6_valid", 32'(out_valid), 0);
      check_eq("t6_fill", 32'(fill_level), 0);
      check_eq("t6_data", 32'(out_data), 0);
      check_eq("t6_last", 32'(out_last), 0);
      check_eq("t6_busy", 32'(flush_busy), 0);
      check_eq("t6_ready", 32'(in_ready), 0);
      check_eq("t6_tmr", 32'(tmr_err), 0);
      step();
      rst_n = 1'b1;
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
